pc_gen: RTL

//  Parametrised fetch-address generator: next generation of the plain PC register.

---
 rtl/pc_gen.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_gen
//  Purpose  : Fetch-address generator. Holds the fetch PC, steps it by STEP
//             on every accepted fetch, and handles stall hold, branch and
//             exception redirects, plus a one-entry pending redirect for
//             redirects that arrive while the pipeline is stalled.
//  Config   : DELAY_SLOT_EN (macro) -- when defined, branch redirects are
//             armed and take effect on the first fire after arming, so the
//             instruction after the branch (delay slot) is still fetched.
//  Ports    :
//    clk         in   1     clock, rising edge
//    rst_n       in   1     reset, synchronous, active-low
//    stall       in   1     1 = hold PC, no fetch fires
//    br_valid    in   1     branch/jump redirect request (pulse)
//    br_target   in   PC_W  branch target
//    exc_valid   in   1     exception/eret redirect request (pulse)
//    exc_target  in   PC_W  exception target
//    fetch_req   out  1     PC valid toward instruction memory
//    fetch_ready in   1     instruction memory accepts pc_out this cycle
//    pc_out      out  PC_W  current fetch address (registered)
//    misalign    out  1     OR of the low ALIGN_BITS bits of pc_out
//  Revision : 1.0 -- initial release
// ============================================================================
module pc_gen #(
  parameter int          PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = 32'hbfc00000,
  parameter int          STEP         = 4,
  parameter int          ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [PC_W-1:0] br_target,
  input  logic            exc_valid,
  input  logic [PC_W-1:0] exc_target,
  output logic            fetch_req,
  input  logic            fetch_ready,
  output logic [PC_W-1:0] pc_out,
  output logic            misalign
);

  localparam logic [PC_W-1:0] C_STEP = PC_W'(STEP);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] pc_q,          pc_d;
  logic            fetch_req_q,   fetch_req_d;
  logic            pend_valid_q,  pend_valid_d;
  logic            pend_is_exc_q, pend_is_exc_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;
`ifdef DELAY_SLOT_EN
  logic            ds_armed_q,    ds_armed_d;
  logic [PC_W-1:0] ds_target_q,   ds_target_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic            w_fire;
  logic            w_pend_exc;
  logic            w_pend_br;
  logic            w_br_take;
  logic [PC_W-1:0] w_br_tgt;

  assign w_fire     = fetch_req_q & fetch_ready & ~stall;
  assign w_pend_exc = pend_valid_q &  pend_is_exc_q;
  assign w_pend_br  = pend_valid_q & ~pend_is_exc_q;

  // Branch source when not stalled: a live branch beats a pending one.
  // A same-cycle exception discards the branch; that is handled by the
  // priority order in the next-state logic.
  always_comb begin
    w_br_take = 1'b0;
    w_br_tgt  = br_target;
    if (br_valid) begin
      w_br_take = 1'b1;
      w_br_tgt  = br_target;
    end else if (w_pend_br) begin
      w_br_take = 1'b1;
      w_br_tgt  = pend_target_q;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d          = pc_q;
    fetch_req_d   = 1'b1;   // request rises on the first edge out of reset
    pend_valid_d  = pend_valid_q;
    pend_is_exc_d = pend_is_exc_q;
    pend_target_d = pend_target_q;
`ifdef DELAY_SLOT_EN
    ds_armed_d    = ds_armed_q;
    ds_target_d   = ds_target_q;
`endif

    if (stall) begin
      // PC holds; capture redirects into the single pending slot.
      // An exception always overwrites; a branch may only replace a branch.
      if (exc_valid) begin
        pend_valid_d  = 1'b1;
        pend_is_exc_d = 1'b1;
        pend_target_d = exc_target;
      end else if (br_valid && !w_pend_exc) begin
        pend_valid_d  = 1'b1;
        pend_is_exc_d = 1'b0;
        pend_target_d = br_target;
      end
    end else begin
      // Any pending redirect is consumed (or superseded) on this edge.
      pend_valid_d  = 1'b0;
      pend_is_exc_d = 1'b0;

      if (exc_valid) begin
        pc_d = exc_target;
`ifdef DELAY_SLOT_EN
        ds_armed_d = 1'b0;
`endif
      end else if (w_pend_exc) begin
        pc_d = pend_target_q;
`ifdef DELAY_SLOT_EN
        ds_armed_d = 1'b0;
`endif
      end else begin
`ifdef DELAY_SLOT_EN
        // Armed target replaces the sequential step on the next fire.
        if (w_fire) begin
          if (ds_armed_q) begin
            pc_d       = ds_target_q;
            ds_armed_d = 1'b0;
          end else begin
            pc_d = pc_q + C_STEP;
          end
        end
        // A new branch arms only when nothing is already armed; a branch
        // arriving in this cycle never takes effect on this same edge.
        if (w_br_take && !ds_armed_q) begin
          ds_armed_d  = 1'b1;
          ds_target_d = w_br_tgt;
        end
`else
        if (w_br_take) begin
          pc_d = w_br_tgt;
        end else if (w_fire) begin
          pc_d = pc_q + C_STEP;
        end
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_VECTOR;
      fetch_req_q   <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_is_exc_q <= 1'b0;
      pend_target_q <= '0;
`ifdef DELAY_SLOT_EN
      ds_armed_q    <= 1'b0;
      ds_target_q   <= '0;
`endif
    end else begin
      pc_q          <= pc_d;
      fetch_req_q   <= fetch_req_d;
      pend_valid_q  <= pend_valid_d;
      pend_is_exc_q <= pend_is_exc_d;
      pend_target_q <= pend_target_d;
`ifdef DELAY_SLOT_EN
      ds_armed_q    <= ds_armed_d;
      ds_target_q   <= ds_target_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pc_out    = pc_q;
  assign fetch_req = fetch_req_q;

  generate
    if (ALIGN_BITS > 0) begin : g_misalign
      assign misalign = |pc_q[ALIGN_BITS-1:0];
    end else begin : g_no_misalign
      assign misalign = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire
